// File: rtl/pic8259_pkg.sv
// rtl/pic8259_pkg.sv - shared state encoding and OCW2 constants for the pic8259 host side
package pic8259_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_PULSE,
      ST_RD_PULSE,
      ST_INTA1,
      ST_INTA_GAP,
      ST_INTA2,
      ST_RECOVER
   } host_state_t;

   localparam logic [7:0] OCW2_NONSPECIFIC_EOI   = 8'h20;
   localparam logic [7:0] OCW2_SPECIFIC_EOI_BASE = 8'h60;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/pic8259_pulse_timer.sv
// rtl/pic8259_pulse_timer.sv - loadable down-counter timing every strobe pulse and gap
module pic8259_pulse_timer #(
   parameter int WIDTH = 1
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic             done
);

   logic [WIDTH-1:0] count;

   // Counts down to 1 and parks there; done marks the last cycle of a phase.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         count <= '0;
      else if (load)
         count <= load_value;
      else if (count > WIDTH'(1))
         count <= count - WIDTH'(1);
   end

   assign done = (count == WIDTH'(1));

endmodule

// File: rtl/pic8259_host_initiator.sv
// rtl/pic8259_host_initiator.sv - CPU-side initiator driving 8259 register strobes and INTA cycles
module pic8259_host_initiator
   import pic8259_pkg::*;
#(
   parameter int PULSE_CYCLES = 1,
   parameter int GAP_CYCLES   = 1
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_write,
   input  logic       cmd_addr,
   input  logic [7:0] cmd_data,
   output logic       rsp_valid,
   output logic [7:0] rsp_data,
   input  logic       int_enable,
   output logic       vector_valid,
   input  logic       vector_ready,
   output logic [7:0] vector,
   input  logic       interrupt_to_cpu,
   output logic       chip_select_n,
   output logic       read_enable_n,
   output logic       write_enable_n,
   output logic       address,
   output logic [7:0] data_bus_out,
   input  logic [7:0] data_bus_in,
   output logic       interrupt_acknowledge_n
);

   localparam int CNT_W = $clog2(max_int(PULSE_CYCLES, GAP_CYCLES) + 1);
   localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES);
   localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES);

   host_state_t      state, state_next;
   logic             inta_start, accept, timer_load, timer_done;
   logic [CNT_W-1:0] timer_load_value;

   pic8259_pulse_timer #(.WIDTH(CNT_W)) u_timer (
      .clock      (clock),
      .reset_n    (reset_n),
      .load       (timer_load),
      .load_value (timer_load_value),
      .done       (timer_done)
   );

   always_comb begin
      state_next = state;
      inta_start = 1'b0;
      accept     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (interrupt_to_cpu && int_enable && !vector_valid) begin
               inta_start = 1'b1;
               state_next = ST_INTA1;
            end else if (cmd_valid) begin
               accept     = 1'b1;
               state_next = cmd_write ? ST_WR_PULSE : ST_RD_PULSE;
            end
         end
         ST_WR_PULSE, ST_RD_PULSE, ST_INTA2: if (timer_done) state_next = ST_RECOVER;
         ST_INTA1:    if (timer_done) state_next = ST_INTA_GAP;
         ST_INTA_GAP: if (timer_done) state_next = ST_INTA2;
         ST_RECOVER:  if (timer_done) state_next = ST_IDLE;
         default:     state_next = ST_IDLE;
      endcase
      timer_load = (state_next != state);
      timer_load_value = (state_next == ST_WR_PULSE || state_next == ST_RD_PULSE ||
                          state_next == ST_INTA1 || state_next == ST_INTA2) ? PULSE_LOAD : GAP_LOAD;
      cmd_ready = (state == ST_IDLE) && !inta_start;
   end

   // Pins are decoded from the next state so they line up with the state register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state                   <= ST_IDLE;
         chip_select_n           <= 1'b1;
         read_enable_n           <= 1'b1;
         write_enable_n          <= 1'b1;
         interrupt_acknowledge_n <= 1'b1;
         address                 <= 1'b0;
         data_bus_out            <= 8'h00;
         rsp_valid               <= 1'b0;
         rsp_data                <= 8'h00;
         vector_valid            <= 1'b0;
         vector                  <= 8'h00;
      end else begin
         state                   <= state_next;
         chip_select_n           <= !(state_next == ST_WR_PULSE || state_next == ST_RD_PULSE);
         write_enable_n          <= !(state_next == ST_WR_PULSE);
         read_enable_n           <= !(state_next == ST_RD_PULSE);
         interrupt_acknowledge_n <= !(state_next == ST_INTA1 || state_next == ST_INTA2);
         if (accept) begin
            address      <= cmd_addr;
            data_bus_out <= cmd_write ? cmd_data : 8'h00;
         end else if (state_next != ST_WR_PULSE) begin
            data_bus_out <= 8'h00;
         end
         rsp_valid <= (state == ST_RD_PULSE) && timer_done;
         if (state == ST_RD_PULSE && timer_done)
            rsp_data <= data_bus_in;
         if (state == ST_INTA2 && timer_done) begin
            vector       <= data_bus_in;
            vector_valid <= 1'b1;
         end else if (vector_ready) begin
            vector_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pic8259_host_initiator.sv
// tb/tb_pic8259_host_initiator.sv - directed self-checking bench for pic8259_host_initiator
module tb_pic8259_host_initiator;
   import pic8259_pkg::*;

   logic clock = 1'b0;
   logic reset_n;
   always #5 clock = ~clock;

   logic       cmd_valid, cmd_ready, cmd_write, cmd_addr, rsp_valid, int_enable;
   logic       vector_valid, vector_ready, interrupt_to_cpu;
   logic       chip_select_n, read_enable_n, write_enable_n, address, interrupt_acknowledge_n;
   logic [7:0] cmd_data, rsp_data, vector, data_bus_out, data_bus_in;

   logic       b_cmd_valid, b_cmd_ready, b_cmd_write, b_cmd_addr, b_rsp_valid, b_int_enable;
   logic       b_vector_valid, b_vector_ready, b_irq;
   logic       b_cs_n, b_re_n, b_we_n, b_address, b_inta_n;
   logic [7:0] b_cmd_data, b_rsp_data, b_vector, b_dbo, b_dbi;

   int total = 0;
   int bad   = 0;

   pic8259_host_initiator #(.PULSE_CYCLES(1), .GAP_CYCLES(1)) dut (
      .clock(clock), .reset_n(reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .int_enable(int_enable), .vector_valid(vector_valid), .vector_ready(vector_ready),
      .vector(vector), .interrupt_to_cpu(interrupt_to_cpu), .chip_select_n(chip_select_n),
      .read_enable_n(read_enable_n), .write_enable_n(write_enable_n), .address(address),
      .data_bus_out(data_bus_out), .data_bus_in(data_bus_in),
      .interrupt_acknowledge_n(interrupt_acknowledge_n)
   );

   pic8259_host_initiator #(.PULSE_CYCLES(3), .GAP_CYCLES(2)) dut_slow (
      .clock(clock), .reset_n(reset_n),
      .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_write(b_cmd_write),
      .cmd_addr(b_cmd_addr), .cmd_data(b_cmd_data), .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data),
      .int_enable(b_int_enable), .vector_valid(b_vector_valid), .vector_ready(b_vector_ready),
      .vector(b_vector), .interrupt_to_cpu(b_irq), .chip_select_n(b_cs_n),
      .read_enable_n(b_re_n), .write_enable_n(b_we_n), .address(b_address),
      .data_bus_out(b_dbo), .data_bus_in(b_dbi),
      .interrupt_acknowledge_n(b_inta_n)
   );

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   logic [7:0] prog_data [4];
   logic       prog_addr [4];
   logic       slow_we   [5];

   initial begin
      prog_data[0] = 8'h1F; prog_addr[0] = 1'b0;
      prog_data[1] = 8'h20; prog_addr[1] = 1'b1;
      prog_data[2] = 8'h0D; prog_addr[2] = 1'b1;
      prog_data[3] = 8'h00; prog_addr[3] = 1'b1;
      slow_we[0] = 1'b0; slow_we[1] = 1'b0; slow_we[2] = 1'b0; slow_we[3] = 1'b1; slow_we[4] = 1'b1;

      reset_n = 1'b0;
      cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_data = 0; int_enable = 0;
      vector_ready = 0; interrupt_to_cpu = 0; data_bus_in = 0;
      b_cmd_valid = 0; b_cmd_write = 0; b_cmd_addr = 0; b_cmd_data = 0; b_int_enable = 0;
      b_vector_ready = 0; b_irq = 0; b_dbi = 0;
      step(); step();

      // reset state
      chk("rst_strobes", {chip_select_n, read_enable_n, write_enable_n, interrupt_acknowledge_n}, 4'hF);
      chk("rst_addr_dbo", {address, data_bus_out}, 9'h000);
      chk("rst_cmd_ready", cmd_ready, 1'b1);
      chk("rst_rsp", {rsp_valid, rsp_data}, 9'h000);
      chk("rst_vector", {vector_valid, vector}, 9'h000);
      reset_n = 1'b1;
      step();

      // write, single-cycle pulse and spacing
      cmd_valid = 1; cmd_write = 1; cmd_addr = 0; cmd_data = 8'h1F;
      #1 chk("wr_ready_idle", cmd_ready, 1'b1);
      step();
      cmd_valid = 0;
      chk("wr_pulse_strobes", {chip_select_n, write_enable_n, read_enable_n}, 3'b001);
      chk("wr_pulse_bus", {address, data_bus_out}, 9'h01F);
      chk("wr_ready_pulse", cmd_ready, 1'b0);
      step();
      chk("wr_recover", {chip_select_n, write_enable_n, data_bus_out}, 10'h300);
      chk("wr_ready_recover", cmd_ready, 1'b0);
      step();
      chk("wr_ready_again", cmd_ready, 1'b1);

      // read
      cmd_valid = 1; cmd_write = 0; cmd_addr = 1; data_bus_in = 8'hA5;
      step();
      cmd_valid = 0;
      chk("rd_pulse", {chip_select_n, read_enable_n, write_enable_n, address}, 4'b0011);
      step();
      chk("rd_rsp", {read_enable_n, rsp_valid, rsp_data}, 10'h3A5);
      step();
      chk("rd_rsp_held", {rsp_valid, rsp_data}, 9'h0A5);

      // INTA sequence, completes after interrupt drops
      int_enable = 1; interrupt_to_cpu = 1; data_bus_in = 8'h20;
      #1 chk("inta_blocks_ready", cmd_ready, 1'b0);
      step();
      interrupt_to_cpu = 0;
      chk("inta1", {interrupt_acknowledge_n, chip_select_n}, 2'b01);
      step();
      chk("inta_gap", interrupt_acknowledge_n, 1'b1);
      step();
      chk("inta2", {interrupt_acknowledge_n, chip_select_n}, 2'b01);
      step();
      chk("inta_vector", {interrupt_acknowledge_n, vector_valid, vector}, 10'h320);
      step();

      // vector pending: no new INTA, EOI still served
      interrupt_to_cpu = 1;
      cmd_valid = 1; cmd_write = 1; cmd_addr = 0; cmd_data = OCW2_NONSPECIFIC_EOI;
      #1 chk("pending_ready", cmd_ready, 1'b1);
      step();
      interrupt_to_cpu = 0; cmd_valid = 0;
      chk("eoi_write", {write_enable_n, interrupt_acknowledge_n, data_bus_out}, 10'h120);
      step(); step();
      chk("vector_held", {vector_valid, vector}, 9'h120);
      vector_ready = 1;
      step();
      vector_ready = 0;
      chk("vector_consumed", vector_valid, 1'b0);

      // simultaneous command and interrupt: INTA first
      cmd_valid = 1; cmd_write = 1; cmd_addr = 1; cmd_data = 8'hFF; interrupt_to_cpu = 1;
      #1 chk("race_ready", cmd_ready, 1'b0);
      step();
      interrupt_to_cpu = 0; data_bus_in = 8'h21;
      chk("race_inta1", {interrupt_acknowledge_n, write_enable_n}, 2'b01);
      step(); step(); step();
      chk("race_vector", {vector_valid, vector}, 9'h121);
      step();
      chk("race_ready_after", cmd_ready, 1'b1);
      step();
      cmd_valid = 0;
      chk("race_write", {write_enable_n, address, data_bus_out}, 10'h1FF);
      step(); step();
      vector_ready = 1;
      step();
      vector_ready = 0;

      // interrupts masked: command only
      int_enable = 0; interrupt_to_cpu = 1;
      cmd_valid = 1; cmd_write = 0; cmd_addr = 0; data_bus_in = 8'h5A;
      #1 chk("masked_ready", cmd_ready, 1'b1);
      step();
      cmd_valid = 0;
      chk("masked_read", {read_enable_n, interrupt_acknowledge_n}, 2'b01);
      step();
      chk("masked_rsp", {rsp_valid, rsp_data}, 9'h15A);
      step(); step();
      chk("masked_no_inta", {interrupt_acknowledge_n, vector_valid}, 2'b10);
      interrupt_to_cpu = 0;

      // reset in the middle of INTA2
      int_enable = 1; interrupt_to_cpu = 1; data_bus_in = 8'h33;
      step(); step(); step();
      chk("mid_inta2", interrupt_acknowledge_n, 1'b0);
      reset_n = 0;
      #1;
      chk("async_reset_strobes", {chip_select_n, read_enable_n, write_enable_n, interrupt_acknowledge_n}, 4'hF);
      chk("async_reset_vector", vector_valid, 1'b0);
      interrupt_to_cpu = 0; int_enable = 0;
      step();
      reset_n = 1;
      step();
      chk("post_reset_ready", cmd_ready, 1'b1);
      chk("post_reset_vector", vector_valid, 1'b0);

      // PULSE=3 GAP=2: EOI timing
      b_cmd_valid = 1; b_cmd_write = 1; b_cmd_addr = 0; b_cmd_data = OCW2_NONSPECIFIC_EOI;
      #1 chk("slow_ready", b_cmd_ready, 1'b1);
      for (int i = 0; i < 5; i++) begin
         step();
         b_cmd_valid = 0;
         chk($sformatf("slow_eoi_we_%0d", i), {b_we_n, b_cmd_ready}, {slow_we[i], 1'b0});
      end
      step();
      chk("slow_idle_ready", b_cmd_ready, 1'b1);

      // full init program back to back
      for (int i = 0; i < 4; i++) begin
         b_cmd_valid = 1; b_cmd_write = 1; b_cmd_addr = prog_addr[i]; b_cmd_data = prog_data[i];
         #1 chk($sformatf("prog_accept_%0d", i), b_cmd_ready, 1'b1);
         step();
         b_cmd_valid = 0;
         chk($sformatf("prog_bus_%0d", i), {b_we_n, b_cs_n, b_address, b_dbo},
             {2'b00, prog_addr[i], prog_data[i]});
         repeat (4) step();
         chk($sformatf("prog_recover_%0d", i), {b_we_n, b_dbo}, 9'h100);
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
